// File: rtl/rom_rr_arb_m.sv
// Round-robin arbiter sharing one ROM read port among N_REQ requesters, with a tag pipeline routing data back.
// Optional request locking is compiled in with `define ROM_ARB_LOCK_EN (adds the req_lock port).
module rom_rr_arb_m #(
    parameter int N_REQ       = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int WORD_WIDTH  = 16,
    parameter int ROM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [WORD_WIDTH-1:0]       resp_data,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [WORD_WIDTH-1:0]       rom_data
`ifdef ROM_ARB_LOCK_EN
    ,
    input  logic [N_REQ-1:0]            req_lock
`endif
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    generate
        if (ROM_LATENCY < 1) begin : g_bad_latency
            $error("rom_rr_arb_m: ROM_LATENCY must be >= 1");
        end
    endgenerate

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] sel_q;
    logic [IDW-1:0] sel;
    logic           found;
    logic           xfer;

`ifdef ROM_ARB_LOCK_EN
    typedef enum logic {ARB, LOCKED} lock_state_e;
    lock_state_e    state, state_next;
    logic [IDW-1:0] owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            owner <= '0;
        end else begin
            state <= state_next;
            if (state == ARB && xfer && req_lock[grant])
                owner <= grant;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (xfer && req_lock[grant])  state_next = LOCKED;
            LOCKED:  if (xfer && !req_lock[owner]) state_next = ARB;
            default: state_next = ARB;
        endcase
    end
`endif

    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
`ifdef ROM_ARB_LOCK_EN
        if (state == LOCKED) begin
            found = req_valid[owner];
            grant = owner;
        end
`endif
    end

    assign xfer = found & ~rst;

    always_comb begin
        req_ready = '0;
        if (xfer)
            req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            sel_q  <= '0;
        end else if (xfer) begin
            rr_ptr <= (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
            sel_q  <= grant;
        end
    end

    // Idle cycles keep the previous mux select so the ROM address does not toggle.
    assign sel      = found ? grant : sel_q;
    assign rom_addr = req_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];

    logic [ROM_LATENCY-1:0] tag_v;
    logic [IDW-1:0]         tag_id [ROM_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= xfer;
            for (int unsigned s = 1; s < ROM_LATENCY; s++)
                tag_v[s] <= tag_v[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant;
        for (int unsigned s = 1; s < ROM_LATENCY; s++)
            tag_id[s] <= tag_id[s-1];
    end

    always_comb begin
        resp_valid = '0;
        if (tag_v[ROM_LATENCY-1])
            resp_valid[tag_id[ROM_LATENCY-1]] = 1'b1;
    end

    assign resp_data = rom_data;

endmodule

// File: doc/rom_rr_arb_m.md
Name: rom_rr_arb_m

Overview:
- Round-robin arbiter that shares one distributed ROM read port between N_REQ requesters.
- The ROM is instantiated outside this block; typically the registered-output variant, so ROM_LATENCY = 1.
- Accepts at most one address per cycle, fully pipelined.
- Tracks the requester ID of each in-flight read and returns the data to that requester after exactly ROM_LATENCY cycles.

Parameters:
- N_REQ, 4: number of requesters, >= 1.
- ADDR_WIDTH, 8: ROM address width.
- WORD_WIDTH, 16: ROM data width.
- ROM_LATENCY, 1: cycles from rom_addr to valid rom_data, >= 1 (0 is illegal; elaboration-time assertion).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester read request.
- req_addr  in  N_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- resp_valid  out  N_REQ  one-cycle pulse, read data for requester i.
- resp_data  out  WORD_WIDTH  read data, shared by all requesters, qualified by resp_valid.
- rom_addr  out  ADDR_WIDTH  to ROM address input.
- rom_data  in  WORD_WIDTH  from ROM data output.
- req_lock  in  N_REQ  present only with ROM_ARB_LOCK_EN.

Behaviour:
- One clock domain (clk); reset asynchronous, active-high.
- Reset values:
  - rr_ptr = 0.
  - Tag pipeline valid bits = 0, so resp_valid = 0.
  - Lock FSM = ARB.
  - req_ready forced to 0 while rst is high.
- Arbitration (combinational, same cycle):
  - grant = first i with req_valid[i] set, searching i = rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ..., rr_ptr-1.
  - req_ready = onehot(grant); all zeros if no req_valid.
  - req_ready may depend on req_valid.
- Pointer update: on a transfer by requester g, rr_ptr <= (g+1) mod N_REQ at the clock edge. rr_ptr is unchanged in idle cycles.
- rom_addr = req_addr slice of the granted requester. In idle cycles it holds its last value (registered mux-select hold, not X), so there is no needless toggling.
- Tag pipeline, ROM_LATENCY stages of {valid, id[$clog2(N_REQ) max 1]}:
  - Stage 0 is loaded on each edge with {transfer, g}.
  - Stage ROM_LATENCY-1 drives resp_valid = valid ? onehot(id) : 0.
- resp_data = rom_data, combinational pass-through; no extra register.
- Latency: a transfer at edge T gives resp_valid and resp_data in cycle T+ROM_LATENCY.
- Throughput: 1 read per cycle sustained. Back-to-back transfers from different or same requesters produce back-to-back responses in issue order.
- No response backpressure: requesters must always accept resp_valid.
- req_valid may drop without a transfer; no state is recorded for it.
- N_REQ = 1: grant = req_valid[0]; rr_ptr stays 0; id width 1.
- rr_ptr wrap: a grant to N_REQ-1 sets rr_ptr = 0.
- Reset mid-operation: in-flight responses are discarded (no resp_valid after rst is released until a new transfer completes).

Optional Feature:
- Macro: ROM_ARB_LOCK_EN.
- Defined: the req_lock port exists, and a 2-state FSM is added.
  - ARB: normal round-robin. A transfer by g with req_lock[g] = 1 sets owner <= g and moves to LOCKED.
  - LOCKED: req_ready = onehot(owner) & req_valid. Other requesters are blocked.
  - A transfer by owner with req_lock[owner] = 0 returns to ARB, and rr_ptr <= owner+1.
  - Owner idle cycles do not release the lock.
  - rst forces ARB.
- Undefined: no req_lock port, no FSM, pure round-robin.

Test Plan:
- Reset, then req_valid = 4'b0000 for 5 cycles -> req_ready = 0 and resp_valid = 0 throughout; rom_addr stable.
- All 4 requesters held valid, addrs 0x10/0x20/0x30/0x40, ROM[a] = a*3 -> grants in order 0,1,2,3,0,...; each resp_valid[i] one cycle after its grant, with data 0x30/0x60/0x90/0xC0.
- Only requester 2 valid for 6 cycles, then requesters 2 and 3 both valid -> requester 2 gets 6 consecutive transfers (1/cycle), then the next grant goes to 3 (rr_ptr = 3).
- ROM_LATENCY = 3, alternating transfers from 1 and 0 -> each resp_valid arrives exactly 3 cycles after its transfer, IDs matching issue order.
- rst asserted one cycle after a transfer by requester 1 (ROM_LATENCY = 2) -> no resp_valid[1] after reset release; the next grant searches from 0.
- ROM_ARB_LOCK_EN: requester 1 transfers with lock = 1 three times, others valid throughout; requester 1 idles 2 cycles, then transfers with lock = 0 -> only requester 1 is granted until its unlock transfer; the next grant goes to 2.
